// File: rtl/draw_crosshair_if.sv
// vga_if: one pixel's worth of VGA timing plus colour.
//   vcount/hcount : 11-bit pixel coordinates
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit colour (4:4:4)
// Modports: out/master drive the stream, in/slave receive it.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport out    (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport in     (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_crosshair.sv
// draw_crosshair: last stage of the game video pipeline. Overlays the aiming
// crosshair on the incoming vga_if stream with exactly one clock of latency.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : overlay enable (game / end screens)
//   mouse_xpos/ypos : cursor position, latched once per frame
//   left_mouse      : raw left button level (synchronised here)
//   magazine_empty  : blink the crosshair while high
//   in              : upstream timing + rgb
//   out             : same timing delayed one clk, rgb with overlay
module draw_crosshair #(
  parameter int          CROSS_HALF   = 12,
  parameter int          CROSS_GAP    = 3,
  parameter int          THICK_HALF   = 1,
  parameter int          RECOIL       = 4,
  parameter int          FLASH_FRAMES = 6,
  parameter int          BLINK_LOG2   = 4,
  parameter logic [11:0] COLOUR       = 12'hF00,
  parameter logic [11:0] FLASH_COLOUR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        left_mouse,
  input  logic        magazine_empty,
  vga_if.in           in,
  vga_if.out          out
);

  localparam int FCW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic {S_IDLE, S_FLASH} state_t;

  state_t              r_state, w_state_nxt;
  logic [FCW-1:0]      r_flash_cnt, w_flash_cnt_nxt;
  logic [BLINK_LOG2:0] r_frame_cnt;
  logic [11:0]         r_cur_x, r_cur_y;
  // [0],[1]: synchroniser stages; [2]: previous synchronised level
  logic [2:0]          r_btn;

  logic [10:0] r_vcount, r_hcount;
  logic        r_vsync, r_hsync, r_vblnk, r_hblnk;
  logic [11:0] r_rgb;

  logic        w_sof;
  logic        w_shot;
  logic        w_flash;
  logic        w_visible;
  logic signed [12:0] w_dx_raw, w_dy_raw;
  logic [12:0] w_dx, w_dy, w_len;
  logic        w_hit_h, w_hit_v, w_pixel_on;
  logic [11:0] w_rgb_nxt;

  assign w_sof   = (in.vcount == '0) && (in.hcount == '0);
  assign w_shot  = r_btn[1] & ~r_btn[2];
  assign w_flash = (r_state == S_FLASH);

  // Button synchroniser and edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn <= '0;
    else     r_btn <= {r_btn[1:0], left_mouse};
  end

  // Cursor and frame counter only move on the frame start strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_frame_cnt <= '0;
    end else if (w_sof) begin
      r_cur_x     <= mouse_xpos;
      r_cur_y     <= mouse_ypos;
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flash_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flash_cnt_nxt = r_flash_cnt;
    if (!enable) begin
      w_state_nxt     = S_IDLE;
      w_flash_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_shot) begin
            w_state_nxt     = S_FLASH;
            w_flash_cnt_nxt = FCW'(FLASH_FRAMES);
          end
        end
        S_FLASH: begin
          // retrigger beats both expiry and the strobe decrement
          if (w_shot)
            w_flash_cnt_nxt = FCW'(FLASH_FRAMES);
          else if (r_flash_cnt == '0)
            w_state_nxt = S_IDLE;
          else if (w_sof)
            w_flash_cnt_nxt = r_flash_cnt - 1'b1;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_flash_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Geometry: distances from the latched cursor, 13-bit signed then abs
  always_comb begin
    w_dx_raw = $signed({2'b00, in.hcount}) - $signed({1'b0, r_cur_x});
    w_dy_raw = $signed({2'b00, in.vcount}) - $signed({1'b0, r_cur_y});
    w_dx     = w_dx_raw[12] ? 13'(-w_dx_raw) : 13'(w_dx_raw);
    w_dy     = w_dy_raw[12] ? 13'(-w_dy_raw) : 13'(w_dy_raw);
    w_len    = 13'(CROSS_HALF) + (w_flash ? 13'(RECOIL) : 13'd0);
    w_hit_h  = (w_dy <= 13'(THICK_HALF)) && (w_dx >= 13'(CROSS_GAP)) && (w_dx <= w_len);
    w_hit_v  = (w_dx <= 13'(THICK_HALF)) && (w_dy >= 13'(CROSS_GAP)) && (w_dy <= w_len);
    w_pixel_on = w_hit_h || w_hit_v;
  end

  assign w_visible = enable && !(magazine_empty && r_frame_cnt[BLINK_LOG2]);

  always_comb begin
    w_rgb_nxt = in.rgb;
    if (!in.hblnk && !in.vblnk && w_visible && w_pixel_on)
      w_rgb_nxt = w_flash ? FLASH_COLOUR : COLOUR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vcount <= '0;
      r_hcount <= '0;
      r_vsync  <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_vcount <= in.vcount;
      r_hcount <= in.hcount;
      r_vsync  <= in.vsync;
      r_hsync  <= in.hsync;
      r_vblnk  <= in.vblnk;
      r_hblnk  <= in.hblnk;
      r_rgb    <= w_rgb_nxt;
    end
  end

  assign out.vcount = r_vcount;
  assign out.hcount = r_hcount;
  assign out.vsync  = r_vsync;
  assign out.hsync  = r_hsync;
  assign out.vblnk  = r_vblnk;
  assign out.hblnk  = r_hblnk;
  assign out.rgb    = r_rgb;

endmodule
